// File: rtl/sub64_pipe.sv
// Two-stage pipelined subtractor: out = in1 - in2 - bin, low half in stage 1, high half in stage 2.
// Optional macro SUB64_CMP_EN adds registered branch-compare outputs lt_u, lt_s and eq.
module sub64_pipe #(
  parameter int WIDTH = 64  // even and >= 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`ifdef SUB64_CMP_EN
  ,
  output logic             lt_u,
  output logic             lt_s,
  output logic             eq
`endif
);

  localparam int H = WIDTH / 2;

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer holds
  // valid and payload until that edge, and ready may depend combinationally on out_ready.
  logic             s1_valid;
  logic [H-1:0]     s1_lo;
  logic             s1_c;
  logic [H-1:0]     s1_a_hi;
  logic [H-1:0]     s1_b_hi;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic             s2_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic             s2_adv;

  logic [H:0]       lo_sum;
  logic [H:0]       hi_sum;
  logic [WIDTH-1:0] result;
  logic             res_ovf;

  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !rst && (!s1_valid || s2_adv);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  // Subtraction as in1 + ~in2 + !bin; carry out of the top is the inverted borrow.
  assign lo_sum  = {1'b0, in1[H-1:0]} + {1'b0, ~in2[H-1:0]} + {{H{1'b0}}, ~bin};
  assign hi_sum  = {1'b0, s1_a_hi} + {1'b0, ~s1_b_hi} + {{H{1'b0}}, s1_c};
  assign result  = {hi_sum[H-1:0], s1_lo};
  assign res_ovf = (s1_a_msb != s1_b_msb) && (result[WIDTH-1] != s1_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_lo    <= lo_sum[H-1:0];
        s1_c     <= lo_sum[H];
        s1_a_hi  <= in1[WIDTH-1:H];
        s1_b_hi  <= in2[WIDTH-1:H];
        s1_a_msb <= in1[WIDTH-1];
        s1_b_msb <= in2[WIDTH-1];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out      <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= 1'b1;
        out      <= result;
        bout     <= ~hi_sum[H];
        zero     <= (result == '0);
        neg      <= result[WIDTH-1];
        ovf      <= res_ovf;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef SUB64_CMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_u <= 1'b0;
      lt_s <= 1'b0;
      eq   <= 1'b0;
    end else if (s2_adv) begin
      lt_u <= ~hi_sum[H];
      lt_s <= result[WIDTH-1] ^ res_ovf;
      eq   <= (result == '0);
    end
  end
`endif

endmodule

// File: tb/tb_sub64_pipe.sv
// Self-checking bench for sub64_pipe: directed vector table, backpressure and reset sequences,
// plus a random-handshake stream scored against an in-order expected queue.
module tb_sub64_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        bin;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        bout, zero, neg, ovf;
`ifdef SUB64_CMP_EN
  logic        lt_u, lt_s, eq;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bi;
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  vec_t        vecs[10];
  logic [67:0] exp_q[$];

  sub64_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bin(bin), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
`ifdef SUB64_CMP_EN
    , .lt_u(lt_u), .lt_s(lt_s), .eq(eq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    logic [64:0] s;
    logic [63:0] d;
    s = {1'b0, a} + {1'b0, ~b} + {64'd0, ~bi};
    d = s[63:0];
    return {d, ~s[64], d == 64'd0, d[63], (a[63] != b[63]) && (d[63] != a[63])};
  endfunction

  // One operation with out_ready held high; result must appear two edges after acceptance.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in1 = v.a; in2 = v.b; bin = v.bi; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 68'(in_ready), 68'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, 68'(out_valid), 68'(0));
    @(negedge clk);
    chk({tag, "_out_valid"}, 68'(out_valid), 68'(1));
    chk({tag, "_out"}, 68'(out), 68'(v.d));
    chk({tag, "_flags"}, 68'({bout, zero, neg, ovf}), 68'({v.bo, v.z, v.n, v.o}));
`ifdef SUB64_CMP_EN
    chk({tag, "_cmp"}, 68'({lt_u, lt_s, eq}), 68'({v.bo, v.n ^ v.o, v.z}));
`endif
  endtask

  task automatic drive_one(input logic [63:0] a, input logic [63:0] b, input logic exp_rdy, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in1 = a; in2 = b; bin = 1'b0;
    #1 chk({tag, "_in_ready"}, 68'(in_ready), 68'(exp_rdy));
  endtask

  initial begin
    vecs[0] = '{64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; bin = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 68'(in_ready), 68'(0));
    chk("rst_out_valid", 68'(out_valid), 68'(0));
    chk("rst_payload", 68'({out, bout, zero, neg, ovf}), 68'(0));
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 68'(in_ready), 68'(1));

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: two operands absorbed, third refused, FIFO order on release.
    @(negedge clk);
    out_ready = 1'b0;
    drive_one(64'd100, 64'd1, 1'b1, "bp_a");
    @(posedge clk);
    drive_one(64'd200, 64'd2, 1'b1, "bp_b");
    @(posedge clk);
    drive_one(64'd300, 64'd3, 1'b0, "bp_c");
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 68'(out_valid), 68'(1));
      chk("bp_hold_out", 68'(out), 68'(99));
      chk("bp_hold_ready", 68'(in_ready), 68'(0));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 68'(in_ready), 68'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second", 68'({out_valid, out}), 68'({1'b1, 64'd198}));
    @(negedge clk);
    chk("bp_third", 68'({out_valid, out}), 68'({1'b1, 64'd297}));
    @(negedge clk);
    chk("bp_drained", 68'(out_valid), 68'(0));

    // Reset with both stages full.
    out_ready = 1'b0;
    drive_one(64'd50, 64'd8, 1'b1, "mr_a");
    @(posedge clk);
    drive_one(64'd60, 64'd9, 1'b1, "mr_b");
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mr_full_valid", 68'(out_valid), 68'(1));
    rst = 1'b1;
    #1 chk("mr_rst_ready", 68'(in_ready), 68'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 68'(out_valid), 68'(0));
    chk("mr_payload", 68'({out, bout, zero, neg, ovf}), 68'(0));
`ifdef SUB64_CMP_EN
    chk("mr_cmp", 68'({lt_u, lt_s, eq}), 68'(0));
`endif
    chk("mr_in_ready", 68'(in_ready), 68'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr_no_ghost", 68'(out_valid), 68'(0));
    run_vec('{64'd3, 64'd2, 1'b0, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0}, "mr_fresh");

    // Random handshake stream scored against the model queue.
    begin
      int sent = 0, got = 0, cyc = 0;
      logic pending = 1'b0;
      logic stalled = 1'b0;
      logic [67:0] prev = '0;
      logic [67:0] cur;
      logic [67:0] exp;
      in_valid = 1'b0;
      while (got < 100 && cyc < 5000) begin
        @(negedge clk);
        cyc++;
        if (!pending) begin
          if (sent < 100 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in1 = {$urandom(), $urandom()};
            in2 = {$urandom(), $urandom()};
            bin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) in2 = in1;
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = 1'($urandom_range(0, 1));
        #1;
        cur = {out, bout, zero, neg, ovf};
        if (stalled) chk("rnd_stable", cur, prev);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rnd_unexpected", 68'(1), 68'(0));
          end else begin
            exp = exp_q.pop_front();
            chk($sformatf("rnd_res%0d", got), cur, exp);
          end
          got++;
        end
        if (!in_ready) chk("rnd_ready_rule", 68'(out_valid && !out_ready), 68'(1));
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in1, in2, bin));
          sent++;
          pending = 1'b0;
        end else begin
          pending = in_valid;
        end
        stalled = out_valid && !out_ready;
        prev = cur;
      end
      in_valid = 1'b0;
      chk("rnd_count", 68'(got), 68'(100));
      chk("rnd_sent", 68'(sent), 68'(100));
      chk("rnd_queue_empty", 68'(exp_q.size()), 68'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub64_pipe.md
Name: sub64_pipe

Overview:
- Two-stage pipelined 64-bit subtractor; the inverse-direction companion of the team's 64-bit carry-lookahead adder.
- Computes out = in1 - in2 - bin.
- Splits the datapath into a low-half stage and a high-half stage with the borrow registered between them.
- Has valid/ready handshakes on both sides, so it drops into the ALU/execute path with backpressure.
- Produces borrow-out plus zero/negative/overflow flags.

Parameters:
- WIDTH, 64, operand width; must be even and >= 4. Stage 1 handles bits [WIDTH/2-1:0], stage 2 handles [WIDTH-1:WIDTH/2].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- bin  input  1  borrow in (1 = subtract an extra 1)
- in1  input  WIDTH  minuend
- in2  input  WIDTH  subtrahend
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  difference, modulo 2^WIDTH
- bout  output  1  borrow out (1 = unsigned in1 < in2 + bin)
- zero  output  1  out == 0
- neg  output  1  out[WIDTH-1]
- ovf  output  1  signed overflow

Behaviour:
- Arithmetic: out = in1 + ~in2 + !bin. With c = carry out of the top bit, bout = !c.
- Overflow: ovf = (in1[MSB] != in2[MSB]) && (out[MSB] != in1[MSB]).
- Stage 1 register, loaded on input transfer (in_valid && in_ready):
  - s1_valid
  - low-half sum
  - low-half carry
  - in1/in2 upper halves
  - in1/in2 MSBs
- Stage 2 register, loaded on stage advance:
  - s2_valid
  - full WIDTH result
  - bout, zero, neg, ovf
- Outputs are driven directly from stage 2 registers; no combinational path from in1/in2 to out.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_adv
  - s2_valid clears on (out_valid && out_ready) when no s2_adv occurs that cycle.
  - s1_valid clears on s2_adv when no new input transfer occurs that cycle.
- Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput is 1 result per cycle.
- Backpressure: with out_ready low, stage 2 holds its payload stable and the block absorbs exactly one further operand in stage 1, after which in_ready = 0. Nothing is dropped or duplicated. Payload is stable while out_valid && !out_ready.
- Simultaneous events: transfer-in, advance, and transfer-out may all occur in one cycle. Data order is strictly FIFO.
- Reset (synchronous, also mid-operation):
  - s1_valid = 0, s2_valid = 0
  - out = 0, bout = 0, zero = 0, neg = 0, ovf = 0
  - in_ready = 1 in the cycle after reset deasserts.
  - In-flight operations are discarded.
- While rst is high, in_ready = 0 and no input is accepted.
- Wrap-around: 0 - 1 gives all-ones with bout = 1. No saturation.

Optional Feature:
- Macro: SUB64_CMP_EN.
- When defined:
  - Extra outputs lt_u = bout, lt_s = neg ^ ovf, and eq = zero, registered in stage 2.
  - lt_u, lt_s, and eq reset to 0.
  - Intended for branch compare (bin must be 0 for compare semantics).
- When undefined: these ports do not exist, and area and timing are unchanged from the base block.

Test Plan:
- Basic: in1 = 10, in2 = 3, bin = 0, out_ready = 1 -> 2 cycles later out = 7, bout = 0, zero = 0, neg = 0, ovf = 0.
- Wrap and borrow:
  - in1 = 0, in2 = 1 -> out = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, neg = 1, ovf = 0.
  - in1 = 5, in2 = 5, bin = 1 -> all-ones, bout = 1.
- Cross-half borrow: in1 = 0x0000_0001_0000_0000, in2 = 1 -> out = 0x0000_0000_FFFF_FFFF, bout = 0, zero = 0.
- Signed overflow:
  - in1 = 0x8000_0000_0000_0000, in2 = 1 -> out = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1, neg = 0.
  - in1 = 0x7FFF_FFFF_FFFF_FFFF, in2 = 0xFFFF_FFFF_FFFF_FFFF -> ovf = 1, neg = 1.
  - Equal operands -> zero = 1, ovf = 0.
- Backpressure:
  - Stream 100 random operand pairs with random in_valid and random out_ready -> results match the reference model in order, with no loss or duplication.
  - Payload is stable while stalled.
  - in_ready = 0 only when both stages are full and out_ready = 0.
- Reset mid-flight: assert rst for 1 cycle with both stages full -> next cycle out_valid = 0 and all outputs are 0; the pipeline then resumes with a fresh operation of 3 - 2 = 1. With SUB64_CMP_EN, in1 = -1, in2 = 1 gives lt_s = 1 and lt_u = 0.
